// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
//   F3_*        : RV32I load/store funct3 encodings
//   lsu_state_t : control FSM states
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_WAIT   = 2'd1,
        STORE_MERGE = 2'd2
    } lsu_state_t;

    // Reserved encodings, plus unsigned variants which have no store form.
    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit (purely combinational).
//   offset     : byte offset within the 32-bit word
//   funct3     : RV32I load/store funct3
//   word       : word read from RAM
//   sdata      : store data, byte/half in the LSBs
//   load_val   : extracted and sign/zero-extended load result
//   store_word : word with the target byte/half replaced by sdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] sdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;

    // Little-endian lanes: offset n lives at bits [8n+7:8n].
    always_comb begin
        byte_sh  = {offset, 3'b000};
        half_sh  = {offset[1], 4'b0000};
        byte_sel = 8'(word >> byte_sh);
        half_sel = 16'(word >> half_sh);
        load_val = word;
        case (funct3)
            F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val = {24'b0, byte_sel};
            F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val = {16'b0, half_sel};
            default: load_val = word;
        endcase
    end

    // Read-modify-write merge for sub-word stores.
    always_comb begin
        store_word = sdata;
        case (funct3[1:0])
            2'b00:   store_word = (word & ~(32'h0000_00FF << byte_sh))
                                | ({24'b0, sdata[7:0]} << byte_sh);
            2'b01:   store_word = (word & ~(32'h0000_FFFF << half_sh))
                                | ({16'b0, sdata[15:0]} << half_sh);
            default: store_word = sdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 1-cycle synchronous word RAM.
//   req_*     : one load/store request at a time (valid/ready)
//   rsp_*     : one-cycle response pulse with error flag and load data
//   ram_*     : word-addressed RAM strobes, driven in the cycle they apply
// Sub-word stores are done as read-modify-write over two cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int unsigned MEM_DEPTH  = 256,
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  ram_wen,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    lsu_state_t            state_q, state_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    logic                  accept;
    logic                  req_err;
    logic                  req_sw;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [31:0]           load_val;
    logic [31:0]           store_word;

    // Upper address bits alias onto the RAM; they are intentionally dropped.
    logic                  unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_word  = req_addr[ADDR_WIDTH+1:2];
    assign req_err   = lsu_illegal(req_we, req_funct3) || lsu_misaligned(req_funct3, req_addr[1:0]);
    assign req_sw    = req_we && (req_funct3 == F3_W);

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    lsu_align u_align (
        .offset     (off_q),
        .funct3     (f3_q),
        .word       (ram_rdata),
        .sdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State and request-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            off_q       <= '0;
            f3_q        <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state logic; full-word stores and errors complete from IDLE.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        f3_d    = f3_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d   = req_addr[1:0];
                    f3_d    = req_funct3;
                    waddr_d = req_word;
                    wdata_d = req_wdata;
                    if (!req_err && !req_sw) begin
                        state_d = req_we ? STORE_MERGE : LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT:   state_d = IDLE;
            STORE_MERGE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // RAM strobes (same cycle) and next response values.
    always_comb begin
        ram_ren     = 1'b0;
        ram_wen     = 1'b0;
        ram_raddr   = req_word;
        ram_waddr   = req_word;
        ram_wdata   = req_wdata;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_sw) begin
                        ram_wen     = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
                        ram_ren = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_val;
            end
            STORE_MERGE: begin
                ram_wen     = 1'b1;
                ram_waddr   = waddr_q;
                ram_wdata   = store_word;
                rsp_valid_d = 1'b1;
            end
            default: ;
        endcase
        // No RAM side effects while reset is held, even mid-RMW.
        if (rst) begin
            ram_ren = 1'b0;
            ram_wen = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural 1-cycle RAM.
module tb_load_store_unit;

    localparam int unsigned MEM_DEPTH  = 256;
    localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;
    logic                  ram_wen;
    logic                  ram_ren;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    logic [31:0] mem [MEM_DEPTH];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .ram_wen    (ram_wen),
        .ram_ren    (ram_ren),
        .ram_waddr  (ram_waddr),
        .ram_raddr  (ram_raddr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Synchronous word RAM: read data valid the cycle after ren.
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ren;
        logic        exp_wen;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ren, input logic wen,
                                input int lat, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_ren = ren; v.exp_wen = wen; v.exp_lat = lat;
        v.exp_err = err; v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one request, record strobes in the accept cycle, wait (bounded) for the response.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic ren_seen, output logic wen_seen,
                           output int lat, output logic err, output logic [31:0] rdata);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        #1;
        ren_seen = ram_ren;
        wen_seen = ram_wen;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; err = 1'b0; rdata = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; err = rsp_err; rdata = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic do_vec(input string tag, input vec_t v);
        logic ren, wen, err;
        int lat;
        logic [31:0] rd;
        run_req(v.we, v.f3, v.addr, v.wdata, ren, wen, lat, err, rd);
        check({tag, ".ren"}, 32'(ren), 32'(v.exp_ren));
        check({tag, ".wen"}, 32'(wen), 32'(v.exp_wen));
        check({tag, ".lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, ".err"}, 32'(err), 32'(v.exp_err));
        check({tag, ".rdata"}, rd, v.exp_rdata);
    endtask

    initial begin : main
        int wen_cnt;
        int rsp_cnt;
        logic rdy [4];
        logic [3:0] exp_rdy;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.rsp_err",   32'(rsp_err),   32'd0);
        check("reset.rsp_rdata", rsp_rdata,      32'd0);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.ram_wen",   32'(ram_wen),   32'd0);
        check("reset.ram_ren",   32'(ram_ren),   32'd0);

        //           we    f3      addr          wdata         ren   wen   lat err   rdata
        vq.push_back(mk(1'b1, 3'b010, 32'h0000_000C, 32'h8899_AABB, 1'b0, 1'b1, 1, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b000, 32'h0000_000D, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hFFFF_FFAA));
        vq.push_back(mk(1'b0, 3'b100, 32'h0000_000D, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h0000_00AA));
        vq.push_back(mk(1'b0, 3'b001, 32'h0000_000E, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hFFFF_8899));
        vq.push_back(mk(1'b0, 3'b101, 32'h0000_000E, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h0000_8899));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_000C, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h8899_AABB));
        vq.push_back(mk(1'b0, 3'b000, 32'h0000_000F, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hFFFF_FF88));
        vq.push_back(mk(1'b0, 3'b100, 32'h0000_000C, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h0000_00BB));
        vq.push_back(mk(1'b0, 3'b001, 32'h0000_000C, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hFFFF_AABB));
        vq.push_back(mk(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 1'b0, 1'b1, 1, 1'b0, 32'h0));
        vq.push_back(mk(1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FFCD, 1'b1, 1'b0, 2, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h1234_CD78));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 1'b1, 1'b0, 2, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hBEEF_CD78));
        vq.push_back(mk(1'b1, 3'b000, 32'h0000_0013, 32'h0000_007F, 1'b1, 1'b0, 2, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h7FEF_CD78));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0010, 32'hABCD_1234, 1'b1, 1'b0, 2, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b101, 32'h0000_0012, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h0000_7FEF));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0006, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0003, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b0, 3'b101, 32'h0000_0001, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b1, 3'b010, 32'h0000_000E, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b0, 3'b110, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b1, 3'b111, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b1, 3'b100, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b1, 3'b101, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1, 1'b1, 32'h0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'h7FEF_1234));
        vq.push_back(mk(1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 1'b1, 1, 1'b0, 32'h0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hCAFE_F00D));
        vq.push_back(mk(1'b0, 3'b000, 32'h0000_0403, 32'h0,         1'b1, 1'b0, 2, 1'b0, 32'hFFFF_FFCA));

        foreach (vq[i]) do_vec($sformatf("v%0d", i), vq[i]);

        // Back-to-back SW: one accept, one write and one response per cycle.
        wen_cnt = 0; rsp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20 + 32'(4 * i);
            req_wdata = 32'hA0 + 32'(i); req_valid = 1'b1;
            #1;
            check($sformatf("sw_burst.ready%0d", i), 32'(req_ready), 32'd1);
            if (ram_wen) wen_cnt++;
            if (rsp_valid) rsp_cnt++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (rsp_valid) rsp_cnt++;
        @(negedge clk);
        if (rsp_valid) rsp_cnt++;
        check("sw_burst.writes", 32'(wen_cnt), 32'd4);
        check("sw_burst.rsps",   32'(rsp_cnt), 32'd4);
        do_vec("sw_burst.rd0", mk(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b0, 2, 1'b0, 32'hA0));
        do_vec("sw_burst.rd3", mk(1'b0, 3'b010, 32'h2C, 32'h0, 1'b1, 1'b0, 2, 1'b0, 32'hA3));

        // LW stream with valid held: ready alternates.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h24; req_valid = 1'b1;
            #1 rdy[i] = req_ready;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_rdy = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lw_stream.ready%0d", i), 32'(rdy[i]), 32'(exp_rdy[i]));
        end

        // Reset during STORE_MERGE: RMW aborted, RAM untouched, response dropped.
        do_vec("rst_rmw.pre", mk(1'b1, 3'b010, 32'h14, 32'h1122_3344, 1'b0, 1'b1, 1, 1'b0, 32'h0));
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'hEE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_rmw.ram_wen", 32'(ram_wen), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rmw.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rmw.req_ready", 32'(req_ready), 32'd1);
        do_vec("rst_rmw.post", mk(1'b0, 3'b010, 32'h14, 32'h0, 1'b1, 1'b0, 2, 1'b0, 32'h1122_3344));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the single-port-per-direction data RAM (32-bit words, 1-cycle synchronous read, no byte enables, no reset) in the rv32i core.
- Accepts one RV32I load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Translates each request into RAM word accesses, performing read-modify-write for sub-word stores.
- Returns an aligned, sign- or zero-extended load result, or a store acknowledge, with misalignment and illegal-op errors flagged.

Parameters:
- MEM_DEPTH, 256, number of 32-bit RAM words; must be a power of 2.
- ADDR_WIDTH (localparam), $clog2(MEM_DEPTH), RAM word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; byte/half taken from the LSBs.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  qualified by rsp_valid; misaligned or illegal funct3.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- ram_wen  out  1  to RAM wen.
- ram_ren  out  1  to RAM ren.
- ram_waddr  out  ADDR_WIDTH  word address.
- ram_raddr  out  ADDR_WIDTH  word address.
- ram_wdata  out  32  full word to write.
- ram_rdata  in  32  RAM read data; valid the cycle after ram_ren.

Behaviour:
- Accept: req_valid & req_ready at rising edge. Word address = req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored (aliasing); no range error.
- Reset values: state IDLE; rsp_valid, rsp_err, rsp_rdata = 0; ram_wen = ram_ren = 0. RAM strobes are forced to 0 in any cycle where rst is high.
- Error check (at accept):
  - Illegal: funct3 in {011, 110, 111}; or store with funct3[2] = 1.
  - Misaligned: H/HU with addr[0] = 1; W with addr[1:0] != 0.
  - On error: no RAM strobe. Next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- States: IDLE, LOAD_WAIT, STORE_MERGE.
- IDLE, legal load:
  - Same cycle: ram_ren = 1, ram_raddr = word address.
  - Latch byte offset and funct3; go to LOAD_WAIT.
- LOAD_WAIT:
  - Extract the byte/half from ram_rdata at the latched offset; sign- or zero-extend per funct3.
  - Register the result into rsp_rdata; set rsp_valid; go to IDLE.
  - Load latency: rsp_valid 2 cycles after accept.
- IDLE, SW:
  - Same cycle: ram_wen = 1, ram_waddr = word address, ram_wdata = req_wdata.
  - rsp_valid (err = 0) the next cycle; stay in IDLE.
- IDLE, SB/SH:
  - Same cycle: ram_ren = 1. Latch address, offset, funct3 and wdata; go to STORE_MERGE.
- STORE_MERGE:
  - ram_wen = 1; ram_wdata = ram_rdata with the target byte/half replaced.
  - rsp_valid the next cycle; go to IDLE. Sub-word store latency 2.
- Byte lanes are little-endian: offset n occupies bits [8n+7:8n].
- rsp_valid is high for exactly one cycle per accepted request; there is no backpressure on the response.
- req_ready = (state == IDLE); it is also high in the cycle rsp_valid pulses.
- Throughput:
  - SW and errors: 1 request per cycle.
  - Loads and sub-word stores: 1 per 2 cycles.
- Requests are serialised, so there is no load/store hazard: a load accepted after a store's rsp sees the stored data.
- Reset mid-operation:
  - Next state is IDLE; no RAM write occurs in the reset cycle.
  - Any pending response is dropped (rsp_valid = 0 after reset).
  - A partially completed RMW leaves the RAM unchanged.

Decomposition:
- lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, LOAD_WAIT, STORE_MERGE}.
- One combinational sub-module, lsu_align:
  - Inputs: offset, funct3, word, store data.
  - Outputs: extended load value and merged store word.
  - Unit-testable in isolation.

Test Plan:
- RAM word 3 preloaded 0x8899AABB. LB addr 0x0D → rsp_rdata 0xFFFFFFAA 2 cycles after accept; LBU 0x0D → 0x000000AA; LH 0x0E → 0xFFFF8899; LHU 0x0E → 0x00008899; LW 0x0C → 0x8899AABB.
- SW addr 0x10 data 0x12345678 → ram_wen in the accept cycle, rsp_valid next cycle; then SB addr 0x11 data 0xFFFFFFCD → RMW, word 4 = 0x1234CD78; SH addr 0x12 data 0xBEEF → word 4 = 0xBEEFCD78.
- LW addr 0x06, SH addr 0x03, funct3 = 011 → no ram_wen/ram_ren, rsp_valid next cycle with rsp_err = 1, rsp_rdata = 0.
- Back-to-back SW every cycle for 4 cycles → 4 writes, 4 rsp pulses, req_ready constantly 1; LW stream → req_ready toggles 1,0,1,0.
- SB accepted, rst asserted during STORE_MERGE → no ram_wen that cycle, target word unchanged, rsp_valid = 0, state IDLE and req_ready = 1 after reset.
- Address 0x400 (MEM_DEPTH = 256) aliases to word 0: SW there, then LW 0x000 returns the written data.
